instruction_fifo: RTL and testbench

INSTRUCTION_FIFO -- requirements
Module: instruction_fifo

---
 rtl/tpu_package.sv | 4 +
 rtl/instruction_fifo.sv | 84 ++++++++
 tb/tb_instruction_fifo.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_package.sv
// Shared TPU-wide constants.
package tpu_package;
   localparam int unsigned INSTR_SIZE = 32;
endpackage

// File: rtl/instruction_fifo.sv
// First-word-fall-through instruction queue: circular buffer with registered occupancy,
// synchronous flush and sticky overflow/underflow flags.
module instruction_fifo
   import tpu_package::*;
#(
   parameter int unsigned INSTR_W   = INSTR_SIZE,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AFULL_LVL = DEPTH - 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       write_i,
   input  logic [INSTR_W-1:0]         instruction_i,
   input  logic                       read_i,
   output logic [INSTR_W-1:0]         instruction_o,
   output logic                       instr_valid_o,
   output logic                       iq_full_o,
   output logic                       iq_afull_o,
   output logic                       iq_empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [INSTR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               push_ok;
   logic               pop_ok;
   logic               is_full;
   logic               is_empty;

   always_comb begin
      is_full  = (count == CNT_W'(DEPTH));
      is_empty = (count == '0);
      pop_ok   = read_i && !flush_i && !is_empty;
      // A pop in the same cycle frees the slot, so a full queue still accepts the push.
      push_ok  = write_i && !flush_i && (!is_full || pop_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow_o  <= 1'b0;
         underflow_o <= 1'b0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (write_i && !push_ok) overflow_o  <= 1'b1;
         if (read_i && is_empty)  underflow_o <= 1'b1;
      end
   end

   // Storage is deliberately not reset; the zero-count gate below hides stale entries.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr] <= instruction_i;
   end

   always_comb begin
      instruction_o = is_empty ? '0 : mem[rd_ptr];
      instr_valid_o = !is_empty;
      iq_empty_o    = is_empty;
      iq_full_o     = is_full;
      iq_afull_o    = (count >= CNT_W'(AFULL_LVL));
      count_o       = count;
   end

endmodule

// File: tb/tb_instruction_fifo.sv
// Directed self-checking bench for instruction_fifo at DEPTH=16, AFULL_LVL=14.
module tb_instruction_fifo;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        write_i = 1'b0;
   logic [31:0] instruction_i = '0;
   logic        read_i = 1'b0;
   logic [31:0] instruction_o;
   logic        instr_valid_o;
   logic        iq_full_o;
   logic        iq_afull_o;
   logic        iq_empty_o;
   logic [4:0]  count_o;
   logic        overflow_o;
   logic        underflow_o;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   instruction_fifo #(.INSTR_W(32), .DEPTH(16), .AFULL_LVL(14)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .write_i(write_i),
      .instruction_i(instruction_i), .read_i(read_i), .instruction_o(instruction_o),
      .instr_valid_o(instr_valid_o), .iq_full_o(iq_full_o), .iq_afull_o(iq_afull_o),
      .iq_empty_o(iq_empty_o), .count_o(count_o), .overflow_o(overflow_o),
      .underflow_o(underflow_o)
   );

   initial forever #5 clk_i = ~clk_i;

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      write_i = 1'b0; read_i = 1'b0; flush_i = 1'b0;
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d);
      write_i = 1'b1; instruction_i = d;
      cycle();
      write_i = 1'b0;
   endtask

   task automatic fill_16();
      for (int i = 1; i <= 16; i++) push_word(32'(i));
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (count_o !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count_o); end
      n_cmp++; if (iq_empty_o !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", iq_empty_o); end
      n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
      n_cmp++; if (iq_full_o !== 1'b0 || iq_afull_o !== 1'b0) begin n_bad++; $display("FAIL reset_full_afull: got %b%b expected 00", iq_full_o, iq_afull_o); end
      n_cmp++; if (instruction_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h expected 0", instruction_o); end
      n_cmp++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b expected 00", overflow_o, underflow_o); end
      cycle();
      rst_i = 1'b0;
   endtask

   task automatic test_fill_drain();
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         push_word(32'(i));
         n_cmp++; if (count_o !== 5'(i)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, i); end
         n_cmp++; if (iq_afull_o !== (i >= 14)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, iq_afull_o, (i >= 14)); end
         n_cmp++; if (iq_full_o !== (i == 16)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b expected %b", i, iq_full_o, (i == 16)); end
      end
      for (int i = 1; i <= 16; i++) begin
         n_cmp++; if (instruction_o !== 32'(i) || instr_valid_o !== 1'b1) begin n_bad++; $display("FAIL drain_head[%0d]: got %h/%b expected %h/1", i, instruction_o, instr_valid_o, i); end
         read_i = 1'b1; cycle(); read_i = 1'b0;
      end
      n_cmp++; if (iq_empty_o !== 1'b1 || instruction_o !== 32'h0) begin n_bad++; $display("FAIL drain_empty: got %b/%h expected 1/0", iq_empty_o, instruction_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      fill_16();
      push_word(32'hAA);
      n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
      n_cmp++; if (count_o !== 5'd16) begin n_bad++; $display("FAIL ovf_count: got %0d expected 16", count_o); end
      for (int i = 1; i <= 16; i++) begin
         n_cmp++; if (instruction_o !== 32'(i)) begin n_bad++; $display("FAIL ovf_pop[%0d]: got %h expected %h", i, instruction_o, i); end
         read_i = 1'b1; cycle(); read_i = 1'b0;
      end
      n_cmp++; if (iq_empty_o !== 1'b1) begin n_bad++; $display("FAIL ovf_empty_after: got %b expected 1", iq_empty_o); end
      flush_i = 1'b1; cycle(); flush_i = 1'b0;
      n_cmp++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky_flush: got %b expected 1", overflow_o); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      fill_16();
      write_i = 1'b1; read_i = 1'b1; instruction_i = 32'hBB;
      cycle();
      write_i = 1'b0; read_i = 1'b0;
      n_cmp++; if (count_o !== 5'd16) begin n_bad++; $display("FAIL fpp_count: got %0d expected 16", count_o); end
      n_cmp++; if (instruction_o !== 32'h2) begin n_bad++; $display("FAIL fpp_head: got %h expected 2", instruction_o); end
      n_cmp++; if (overflow_o !== 1'b0) begin n_bad++; $display("FAIL fpp_no_ovf: got %b expected 0", overflow_o); end
      for (int i = 1; i <= 16; i++) begin
         logic [31:0] exp;
         exp = (i == 16) ? 32'hBB : 32'(i + 1);
         n_cmp++; if (instruction_o !== exp) begin n_bad++; $display("FAIL fpp_pop[%0d]: got %h expected %h", i, instruction_o, exp); end
         read_i = 1'b1; cycle(); read_i = 1'b0;
      end
   endtask

   task automatic test_empty_rw();
      do_reset();
      write_i = 1'b1; read_i = 1'b1; instruction_i = 32'h55;
      cycle();
      write_i = 1'b0; read_i = 1'b0;
      n_cmp++; if (underflow_o !== 1'b1) begin n_bad++; $display("FAIL erw_udf: got %b expected 1", underflow_o); end
      n_cmp++; if (instruction_o !== 32'h55) begin n_bad++; $display("FAIL erw_head: got %h expected 55", instruction_o); end
      n_cmp++; if (count_o !== 5'd1) begin n_bad++; $display("FAIL erw_count: got %0d expected 1", count_o); end
      flush_i = 1'b1; cycle(); flush_i = 1'b0;
      n_cmp++; if (underflow_o !== 1'b1) begin n_bad++; $display("FAIL erw_udf_sticky: got %b expected 1", underflow_o); end
   endtask

   task automatic test_random_stream();
      logic [31:0] q[$];
      logic [31:0] d;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         d = $urandom;
         write_i = 1'b1; instruction_i = d;
         read_i = (q.size() == 16) || (q.size() > 0 && $urandom_range(0, 1) == 1);
         if (read_i) begin
            n_cmp++; if (instruction_o !== q[0]) begin n_bad++; $display("FAIL rnd_pop[%0d]: got %h expected %h", i, instruction_o, q[0]); end
            void'(q.pop_front());
         end
         q.push_back(d);
         cycle();
         write_i = 1'b0; read_i = 1'b0;
         n_cmp++; if (count_o !== 5'(q.size())) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count_o, q.size()); end
         repeat ($urandom_range(0, 2)) cycle();
      end
      while (q.size() > 0) begin
         n_cmp++; if (instruction_o !== q[0]) begin n_bad++; $display("FAIL rnd_drain: got %h expected %h", instruction_o, q[0]); end
         void'(q.pop_front());
         read_i = 1'b1; cycle(); read_i = 1'b0;
      end
      n_cmp++; if (iq_empty_o !== 1'b1 || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_bad++; $display("FAIL rnd_end_state: got %b%b%b expected 100", iq_empty_o, overflow_o, underflow_o); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 1; i <= 5; i++) push_word(32'h10 + 32'(i));
      flush_i = 1'b1; write_i = 1'b1; instruction_i = 32'hEE;
      cycle();
      flush_i = 1'b0; write_i = 1'b0;
      n_cmp++; if (count_o !== 5'd0 || iq_empty_o !== 1'b1) begin n_bad++; $display("FAIL flush_count: got %0d/%b expected 0/1", count_o, iq_empty_o); end
      n_cmp++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_bad++; $display("FAIL flush_flags: got %b%b expected 00", overflow_o, underflow_o); end
      n_cmp++; if (instruction_o !== 32'h0) begin n_bad++; $display("FAIL flush_instr: got %h expected 0", instruction_o); end
      push_word(32'h77);
      n_cmp++; if (instruction_o !== 32'h77 || count_o !== 5'd1) begin n_bad++; $display("FAIL flush_then_push: got %h/%0d expected 77/1", instruction_o, count_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 1; i <= 5; i++) push_word(32'h20 + 32'(i));
      #3 rst_i = 1'b1;
      #1;
      n_cmp++; if (count_o !== 5'd0 || instr_valid_o !== 1'b0 || iq_empty_o !== 1'b1) begin n_bad++; $display("FAIL arst_state: got %0d/%b/%b expected 0/0/1", count_o, instr_valid_o, iq_empty_o); end
      n_cmp++; if (instruction_o !== 32'h0) begin n_bad++; $display("FAIL arst_instr: got %h expected 0", instruction_o); end
      #1 rst_i = 1'b0;
      cycle();
      push_word(32'h99);
      push_word(32'h9A);
      n_cmp++; if (instruction_o !== 32'h99 || count_o !== 5'd2) begin n_bad++; $display("FAIL arst_first_word: got %h/%0d expected 99/2", instruction_o, count_o); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_push_pop();
      test_empty_rw();
      test_random_stream();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
